// File: rtl/act_stream_pkg.sv
// Shared types and defaults for the activation output stream stages.
package act_stream_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef logic [31:0] act_word_t;

    // Beat as seen by downstream valid/ready stages.
    typedef struct packed {
        act_word_t data;
        logic      last;
    } act_beat_t;

endpackage

// File: rtl/act_sync_fifo.sv
// Single-clock FIFO: pointer/count bookkeeping and register-array storage.
module act_sync_fifo
    import act_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Storage kept out of the reset branch so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/hardsigmoid_out_framer.sv
// HardSigmoid output framer: FIFO buffering, drop detection, tensor framing.
// Optional tensor checksum enabled by defining HSIG_FRAMER_CHECKSUM_EN.
module hardsigmoid_out_framer
    import act_stream_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int DEPTH      = 16,
    parameter int TENSOR_LEN = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_in,
    input  logic [DATA_W-1:0]                 input_data,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 output_data,
    output logic                              out_last,
    output logic [$clog2(TENSOR_LEN+1)-1:0]   elem_idx,
    output logic                              frame_done,
    output logic                              overflow,
    output logic [DATA_W-1:0]                 checksum,
    output logic                              checksum_vld
);

    localparam int IDX_W = $clog2(TENSOR_LEN + 1);

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic [IDX_W-1:0] elem_idx_reg;
    logic             frame_done_reg;
    logic             overflow_reg;

    // The operator cannot stall, so a beat arriving while full is lost even if a pop frees a slot.
    assign push = valid_in && !full;
    assign drop = valid_in && full;
    assign pop  = out_valid && out_ready;

    act_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (input_data),
        .pop     (pop),
        .rd_data (output_data),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready   = !full;
    assign out_valid  = !empty;
    assign out_last   = out_valid && (elem_idx_reg == IDX_W'(TENSOR_LEN - 1));
    assign elem_idx   = elem_idx_reg;
    assign frame_done = frame_done_reg;
    assign overflow   = overflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_idx_reg   <= '0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            frame_done_reg <= pop && out_last;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (pop) begin
                elem_idx_reg <= out_last ? '0 : elem_idx_reg + 1'b1;
            end
        end
    end

`ifdef HSIG_FRAMER_CHECKSUM_EN
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] checksum_reg;
    logic              checksum_vld_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg          <= '0;
            checksum_reg     <= '0;
            checksum_vld_reg <= 1'b0;
        end else begin
            checksum_vld_reg <= 1'b0;
            if (pop) begin
                if (out_last) begin
                    checksum_reg     <= acc_reg + output_data;
                    checksum_vld_reg <= 1'b1;
                    acc_reg          <= '0;
                end else begin
                    acc_reg <= acc_reg + output_data;
                end
            end
        end
    end

    assign checksum     = checksum_reg;
    assign checksum_vld = checksum_vld_reg;
`else
    assign checksum     = '0;
    assign checksum_vld = 1'b0;
`endif

endmodule

// File: tb/tb_hardsigmoid_out_framer.sv
// Directed bench for hardsigmoid_out_framer (DEPTH=16, TENSOR_LEN=4).
module tb_hardsigmoid_out_framer;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 16;
    localparam int TENSOR_LEN = 4;
    localparam int IDX_W      = $clog2(TENSOR_LEN + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              valid_in = 1'b0;
    logic [DATA_W-1:0] input_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] output_data;
    logic              out_last;
    logic [IDX_W-1:0]  elem_idx;
    logic              frame_done;
    logic              overflow;
    logic [DATA_W-1:0] checksum;
    logic              checksum_vld;

    int compared = 0;
    int mismatched = 0;

    hardsigmoid_out_framer #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .TENSOR_LEN (TENSOR_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .input_data   (input_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .output_data  (output_data),
        .out_last     (out_last),
        .elem_idx     (elem_idx),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .checksum     (checksum),
        .checksum_vld (checksum_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        valid_in  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
    endtask

    logic [31:0] t1_beats [3];
    logic [31:0] t6_beats [8];
    logic [31:0] q [$];
    logic [31:0] held;
    logic        stalled;
    logic [31:0] exp_ck;
    logic        exp_vld;

    initial begin
        t1_beats = '{32'h3F00_0000, 32'h3F80_0000, 32'h0000_0000};
        t6_beats = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'd10, 32'd20, 32'd30, 32'd40};

        // Reset state
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_elem_idx", 32'(elem_idx), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_checksum", checksum, 32'd0);
        check("rst_checksum_vld", 32'(checksum_vld), 32'd0);

        // Three beats, each visible one cycle after push
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_in   = 1'b1;
            input_data = t1_beats[i];
            tick();
            valid_in = 1'b0;
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_data", output_data, t1_beats[i]);
            check("t1_idx", 32'(elem_idx), 32'(i));
            tick();
            check("t1_empty", 32'(out_valid), 32'd0);
            $display("t1 beat %0d data %h", i, t1_beats[i]);
        end
        check("t1_overflow", 32'(overflow), 32'd0);

        // Fill to DEPTH with consumer stalled, 17th beat dropped
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            valid_in   = 1'b1;
            input_data = 32'h100 + 32'(i - 1);
            tick();
            check("t2_in_ready", 32'(in_ready), (i < 16) ? 32'd1 : 32'd0);
            check("t2_overflow", 32'(overflow), (i == 17) ? 32'd1 : 32'd0);
            check("t2_head", output_data, 32'h100);
            $display("t2 push %0d in_ready %0b overflow %0b", i, in_ready, overflow);
        end
        valid_in  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2_drain_valid", 32'(out_valid), 32'd1);
            check("t2_drain_data", output_data, 32'h100 + 32'(i));
            tick();
        end
        check("t2_drained", 32'(out_valid), 32'd0);
        check("t2_overflow_sticky", 32'(overflow), 32'd1);
        $display("t2 drain done");

        // Mid-stream reset discards beats and clears overflow
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_in   = 1'b1;
            input_data = 32'h50 + 32'(i);
            tick();
        end
        valid_in  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("t5_idx_before", 32'(elem_idx), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid_after_rst", 32'(out_valid), 32'd0);
        check("t5_in_ready_after_rst", 32'(in_ready), 32'd1);
        check("t5_overflow_after_rst", 32'(overflow), 32'd0);
        valid_in   = 1'b1;
        input_data = 32'hAA;
        tick();
        valid_in = 1'b0;
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_data", output_data, 32'hAA);
        check("t5_idx", 32'(elem_idx), 32'd0);
        $display("t5 post-reset beat %h idx %0d", output_data, elem_idx);

        // Framing: 8 beats, tensors of 4
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            valid_in   = 1'b1;
            input_data = 32'(k);
            tick();
            check("t3_data", output_data, 32'(k));
            check("t3_idx", 32'(elem_idx), 32'((k - 1) % 4));
            check("t3_last", 32'(out_last), (k % 4 == 0) ? 32'd1 : 32'd0);
            check("t3_frame_done", 32'(frame_done), (k == 5) ? 32'd1 : 32'd0);
            $display("t3 beat %0d idx %0d last %0b frame_done %0b", k, elem_idx, out_last, frame_done);
        end
        valid_in = 1'b0;
        tick();
        check("t3_frame_done_end", 32'(frame_done), 32'd1);
        check("t3_empty", 32'(out_valid), 32'd0);
        check("t3_idx_wrap", 32'(elem_idx), 32'd0);
        tick();
        check("t3_frame_done_clear", 32'(frame_done), 32'd0);

        // Alternating backpressure while pushing every cycle
        do_reset();
        q.delete();
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 12; c++) begin
            valid_in   = 1'b1;
            input_data = 32'h200 + 32'(c);
            out_ready  = (c % 2 == 0);
            check("t4_valid", 32'(out_valid), (q.size() != 0) ? 32'd1 : 32'd0);
            if (stalled) check("t4_stable", output_data, held);
            if (out_ready && q.size() != 0) begin
                check("t4_data", output_data, q[0]);
                $display("t4 pop %h", q[0]);
                void'(q.pop_front());
            end
            stalled = (q.size() != 0) && !out_ready;
            held    = output_data;
            q.push_back(input_data);
            tick();
        end
        valid_in  = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 40 && q.size() != 0; g++) begin
            check("t4_drain_valid", 32'(out_valid), 32'd1);
            check("t4_drain_data", output_data, q[0]);
            $display("t4 pop %h", q[0]);
            void'(q.pop_front());
            tick();
        end
        check("t4_empty", 32'(out_valid), 32'd0);
        check("t4_overflow", 32'(overflow), 32'd0);

        // Tensor checksum (constant zero when the feature is compiled out)
        do_reset();
        out_ready = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            valid_in   = (e <= 8);
            input_data = (e <= 8) ? t6_beats[e - 1] : 32'd0;
            tick();
`ifdef HSIG_FRAMER_CHECKSUM_EN
            exp_vld = (e == 5) || (e == 9);
            exp_ck  = (e >= 9) ? 32'd100 : ((e >= 5) ? 32'd5 : 32'd0);
`else
            exp_vld = 1'b0;
            exp_ck  = 32'd0;
`endif
            check("t6_checksum_vld", 32'(checksum_vld), 32'(exp_vld));
            check("t6_checksum", checksum, exp_ck);
            $display("t6 cycle %0d checksum %h vld %0b", e, checksum, checksum_vld);
        end
        valid_in = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
